// File: rtl/ls_queue_pkg.sv
// ls_queue_pkg: opcode and width constants shared by the load/store queue and reservation stations.
// Rev 1.0
`default_nettype none

package ls_queue_pkg;

  localparam int ROBEN_W_DEF = 5;
  localparam int DATA_W_DEF  = 32;
  localparam int OPCODE_W    = 12;

  localparam logic [OPCODE_W-1:0] OP_LW = 12'h103;
  localparam logic [OPCODE_W-1:0] OP_SW = 12'h123;

  function automatic logic is_store(input logic [OPCODE_W-1:0] op);
    return op == OP_SW;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ls_queue_cdb_match.sv
// ls_cdb_match: compares one source tag against all CDB ports, lowest-numbered hit wins.
// Rev 1.0
`default_nettype none

module ls_cdb_match
  import ls_queue_pkg::*;
#(
  parameter int NCDB    = 2,
  parameter int ROBEN_W = ROBEN_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic [ROBEN_W-1:0]      tag,
  input  logic [NCDB-1:0]         cdb_valid,
  input  logic [NCDB*ROBEN_W-1:0] cdb_roben,
  input  logic [NCDB*DATA_W-1:0]  cdb_val,
  output logic                    hit,
  output logic [DATA_W-1:0]       val
);

  // Scan from the top port down so the lowest-numbered match is written last.
  always_comb begin
    hit = 1'b0;
    val = '0;
    for (int p = NCDB - 1; p >= 0; p--) begin
      if (cdb_valid[p] && (cdb_roben[p*ROBEN_W +: ROBEN_W] != '0) &&
          (cdb_roben[p*ROBEN_W +: ROBEN_W] == tag)) begin
        hit = 1'b1;
        val = cdb_val[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ls_queue.sv
// ls_queue: in-order load/store queue with CDB wakeup; stores wait for the ROB head to commit.
// Rev 1.0
`default_nettype none

module ls_queue
  import ls_queue_pkg::*;
#(
  parameter  int DEPTH   = 8,
  parameter  int NCDB    = 2,
  parameter  int ROBEN_W = ROBEN_W_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROBEN_W-1:0]      in_roben,
  input  logic [4:0]              in_rd,
  input  logic [11:0]             in_opcode,
  input  logic [ROBEN_W-1:0]      in_q1,
  input  logic [ROBEN_W-1:0]      in_q2,
  input  logic [DATA_W-1:0]       in_v1,
  input  logic [DATA_W-1:0]       in_v2,
  input  logic [DATA_W-1:0]       in_imm,
  input  logic [DATA_W-1:0]       in_ea,
  input  logic [ROBEN_W-1:0]      rob_head,
  input  logic                    flush,
  input  logic [NCDB-1:0]         cdb_valid,
  input  logic [NCDB*ROBEN_W-1:0] cdb_roben,
  input  logic [NCDB*DATA_W-1:0]  cdb_val,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ROBEN_W-1:0]      out_roben,
  output logic [4:0]              out_rd,
  output logic [11:0]             out_opcode,
  output logic [DATA_W-1:0]       out_v1,
  output logic [DATA_W-1:0]       out_v2,
  output logic [DATA_W-1:0]       out_imm,
  output logic [DATA_W-1:0]       out_ea,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]   busy;
  logic [ROBEN_W-1:0] e_roben [DEPTH];
  logic [ROBEN_W-1:0] e_q1    [DEPTH];
  logic [ROBEN_W-1:0] e_q2    [DEPTH];
  logic [4:0]         e_rd    [DEPTH];
  logic [11:0]        e_op    [DEPTH];
  logic [DATA_W-1:0]  e_v1    [DEPTH];
  logic [DATA_W-1:0]  e_v2    [DEPTH];
  logic [DATA_W-1:0]  e_imm   [DEPTH];
  logic [DATA_W-1:0]  e_ea    [DEPTH];

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;

  logic [DEPTH-1:0]   hit1;
  logic [DEPTH-1:0]   hit2;
  logic [DATA_W-1:0]  val1 [DEPTH];
  logic [DATA_W-1:0]  val2 [DEPTH];
  logic               in_hit1;
  logic               in_hit2;
  logic [DATA_W-1:0]  in_val1;
  logic [DATA_W-1:0]  in_val2;

  logic               head_ready;
  logic               push;
  logic               pop;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      ls_cdb_match #(.NCDB(NCDB), .ROBEN_W(ROBEN_W), .DATA_W(DATA_W)) u_match1 (
        .tag(e_q1[i]), .cdb_valid(cdb_valid), .cdb_roben(cdb_roben), .cdb_val(cdb_val),
        .hit(hit1[i]), .val(val1[i])
      );
      ls_cdb_match #(.NCDB(NCDB), .ROBEN_W(ROBEN_W), .DATA_W(DATA_W)) u_match2 (
        .tag(e_q2[i]), .cdb_valid(cdb_valid), .cdb_roben(cdb_roben), .cdb_val(cdb_val),
        .hit(hit2[i]), .val(val2[i])
      );
    end
  endgenerate

  // Incoming tags are snooped too, so a same-cycle broadcast is not lost.
  ls_cdb_match #(.NCDB(NCDB), .ROBEN_W(ROBEN_W), .DATA_W(DATA_W)) u_in_match1 (
    .tag(in_q1), .cdb_valid(cdb_valid), .cdb_roben(cdb_roben), .cdb_val(cdb_val),
    .hit(in_hit1), .val(in_val1)
  );
  ls_cdb_match #(.NCDB(NCDB), .ROBEN_W(ROBEN_W), .DATA_W(DATA_W)) u_in_match2 (
    .tag(in_q2), .cdb_valid(cdb_valid), .cdb_roben(cdb_roben), .cdb_val(cdb_val),
    .hit(in_hit2), .val(in_val2)
  );

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;

  assign head_ready = busy[head] && (e_q1[head] == '0) && (e_q2[head] == '0) &&
                      (!is_store(e_op[head]) || (e_roben[head] == rob_head));
  assign push = in_valid && in_ready && !flush;
  assign pop  = head_ready && (!out_valid || out_ready) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_roben  <= '0;
      out_rd     <= '0;
      out_opcode <= '0;
      out_v1     <= '0;
      out_v2     <= '0;
      out_imm    <= '0;
      out_ea     <= '0;
    end else if (flush) begin
      busy      <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        busy[tail] <= 1'b1;
        tail       <= tail + PTR_W'(1);
      end
      if (pop) begin
        busy[head] <= 1'b0;
        head       <= head + PTR_W'(1);
        out_valid  <= 1'b1;
        out_roben  <= e_roben[head];
        out_rd     <= e_rd[head];
        out_opcode <= e_op[head];
        out_v1     <= e_v1[head];
        out_v2     <= e_v2[head];
        out_imm    <= e_imm[head];
        out_ea     <= e_ea[head];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Payload carries no reset; busy alone decides whether an entry is live.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && hit1[i]) begin
          e_q1[i] <= '0;
          e_v1[i] <= val1[i];
          e_ea[i] <= val1[i] + e_imm[i];
        end
        if (busy[i] && hit2[i]) begin
          e_q2[i] <= '0;
          e_v2[i] <= val2[i];
        end
      end
      if (push) begin
        e_roben[tail] <= in_roben;
        e_rd[tail]    <= in_rd;
        e_op[tail]    <= in_opcode;
        e_imm[tail]   <= in_imm;
        e_q1[tail]    <= in_hit1 ? '0 : in_q1;
        e_v1[tail]    <= in_hit1 ? in_val1 : in_v1;
        e_ea[tail]    <= in_hit1 ? (in_val1 + in_imm) : in_ea;
        e_q2[tail]    <= in_hit2 ? '0 : in_q2;
        e_v2[tail]    <= in_hit2 ? in_val2 : in_v2;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ls_queue.sv
// tb_ls_queue: directed and randomized checks of ls_queue against a queue-based reference model.
// Rev 1.0
`default_nettype none

module tb_ls_queue;
  import ls_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int NCDB  = 2;
  localparam int RW    = 5;
  localparam int DW    = 32;
  localparam int CW    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [RW-1:0]     in_roben;
  logic [4:0]        in_rd;
  logic [11:0]       in_opcode;
  logic [RW-1:0]     in_q1, in_q2;
  logic [DW-1:0]     in_v1, in_v2, in_imm, in_ea;
  logic [RW-1:0]     rob_head;
  logic              flush;
  logic [NCDB-1:0]   cdb_valid;
  logic [NCDB*RW-1:0] cdb_roben;
  logic [NCDB*DW-1:0] cdb_val;
  logic              out_valid;
  logic              out_ready;
  logic [RW-1:0]     out_roben;
  logic [4:0]        out_rd;
  logic [11:0]       out_opcode;
  logic [DW-1:0]     out_v1, out_v2, out_imm, out_ea;
  logic [CW-1:0]     count;
  logic              full, empty;

  ls_queue #(.DEPTH(DEPTH), .NCDB(NCDB), .ROBEN_W(RW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_roben(in_roben), .in_rd(in_rd), .in_opcode(in_opcode),
    .in_q1(in_q1), .in_q2(in_q2), .in_v1(in_v1), .in_v2(in_v2),
    .in_imm(in_imm), .in_ea(in_ea), .rob_head(rob_head), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_roben(cdb_roben), .cdb_val(cdb_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_roben(out_roben),
    .out_rd(out_rd), .out_opcode(out_opcode), .out_v1(out_v1), .out_v2(out_v2),
    .out_imm(out_imm), .out_ea(out_ea), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] roben, q1, q2;
    logic [4:0]    rd;
    logic [11:0]   op;
    logic [DW-1:0] v1, v2, imm, ea;
  } ent_t;

  ent_t mq[$];
  ent_t mout;
  bit   mout_valid;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic bit cdb_lookup(input logic [RW-1:0] tag, output logic [DW-1:0] v);
    v = '0;
    if (tag == '0) return 1'b0;
    for (int p = 0; p < NCDB; p++) begin
      if (cdb_valid[p] && cdb_roben[p*RW +: RW] == tag) begin
        v = cdb_val[p*DW +: DW];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic void wake(inout ent_t e);
    logic [DW-1:0] v;
    if (cdb_lookup(e.q1, v)) begin
      e.q1 = '0; e.v1 = v; e.ea = v + e.imm;
    end
    if (cdb_lookup(e.q2, v)) begin
      e.q2 = '0; e.v2 = v;
    end
  endfunction

  // One clock edge of the reference behaviour, using inputs stable before the edge.
  function automatic void model_step();
    ent_t e;
    int   n;
    if (flush) begin
      mq.delete();
      mout_valid = 1'b0;
      return;
    end
    n = mq.size();
    if (n > 0 && mq[0].q1 == '0 && mq[0].q2 == '0 &&
        (mq[0].op != OP_SW || mq[0].roben == rob_head) && (!mout_valid || out_ready)) begin
      mout = mq.pop_front();
      mout_valid = 1'b1;
    end else if (out_ready) begin
      mout_valid = 1'b0;
    end
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      wake(e);
      mq[i] = e;
    end
    if (in_valid && n < DEPTH) begin
      e.roben = in_roben; e.rd = in_rd; e.op = in_opcode;
      e.q1 = in_q1; e.q2 = in_q2; e.v1 = in_v1; e.v2 = in_v2;
      e.imm = in_imm; e.ea = in_ea;
      wake(e);
      mq.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("count",     64'(count),     64'(mq.size()));
      chk("full",      64'(full),      64'(mq.size() == DEPTH));
      chk("empty",     64'(empty),     64'(mq.size() == 0));
      chk("in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
      chk("out_valid", 64'(out_valid), 64'(mout_valid));
      if (mout_valid) begin
        chk("out_roben",  64'(out_roben),  64'(mout.roben));
        chk("out_rd",     64'(out_rd),     64'(mout.rd));
        chk("out_opcode", 64'(out_opcode), 64'(mout.op));
        chk("out_v1",     64'(out_v1),     64'(mout.v1));
        chk("out_v2",     64'(out_v2),     64'(mout.v2));
        chk("out_imm",    64'(out_imm),    64'(mout.imm));
        chk("out_ea",     64'(out_ea),     64'(mout.ea));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; cdb_valid = '0; out_ready = 1'b1;
  endtask

  task automatic enq(input logic [11:0] op, input int rb, input int q1, input int q2,
                     input logic [DW-1:0] imm, input logic [DW-1:0] ea);
    in_valid = 1'b1; in_opcode = op; in_roben = RW'(rb); in_rd = 5'(rb + 3);
    in_q1 = RW'(q1); in_q2 = RW'(q2); in_v1 = 32'h1000 + DW'(rb);
    in_v2 = 32'h2000 + DW'(rb); in_imm = imm; in_ea = ea;
  endtask

  task automatic reset_checks();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ea", 64'(out_ea), 64'd0);
    chk("rst_out_roben", 64'(out_roben), 64'd0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    mq.delete();
    mout_valid = 1'b0;
    #1 reset_checks();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rob_head = '0; in_roben = '0; in_rd = '0; in_opcode = '0; in_q1 = '0; in_q2 = '0;
    in_v1 = '0; in_v2 = '0; in_imm = '0; in_ea = '0; cdb_roben = '0; cdb_val = '0;
    #1 reset_checks();
    step(); step();
    rst = 1'b0;

    // Ready load issues one edge after it lands.
    enq(OP_LW, 1, 0, 0, 32'd4, 32'h40);
    step();
    chk("lw_count1", 64'(count), 64'd1);
    idle();
    step();
    chk("lw_issue_valid", 64'(out_valid), 64'd1);
    chk("lw_issue_ea", 64'(out_ea), 64'h40);
    chk("lw_issue_roben", 64'(out_roben), 64'd1);
    chk("lw_count0", 64'(count), 64'd0);

    // Wakeup on CDB port 1 recomputes ea = value + imm.
    enq(OP_LW, 2, 3, 0, 32'd8, 32'd0);
    step();
    idle();
    cdb_valid = 2'b10;
    cdb_roben = {5'd3, 5'd0};
    cdb_val = {32'd100, 32'd0};
    step();
    chk("wake_not_yet", 64'(out_valid), 64'd0);
    idle();
    step();
    chk("wake_valid", 64'(out_valid), 64'd1);
    chk("wake_ea", 64'(out_ea), 64'd108);
    chk("wake_v1", 64'(out_v1), 64'd100);

    // Store blocked until it reaches the ROB head; younger load waits behind it.
    rob_head = 5'd2;
    enq(OP_SW, 4, 0, 0, 32'd0, 32'h80);
    step();
    enq(OP_LW, 5, 0, 0, 32'd0, 32'h90);
    step();
    idle();
    step(); step();
    chk("sw_blocked", 64'(out_valid), 64'd0);
    chk("sw_blocked_count", 64'(count), 64'd2);
    rob_head = 5'd4;
    step();
    chk("sw_issue_op", 64'(out_opcode), 64'(OP_SW));
    chk("sw_issue_roben", 64'(out_roben), 64'd4);
    step();
    chk("lw_after_sw", 64'(out_roben), 64'd5);
    step();

    // Fill, refuse, pop one, refill with wrap.
    for (int k = 0; k < DEPTH; k++) begin
      enq(OP_LW, 8 + k, 7, 0, DW'(k), 32'd0);
      step();
    end
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    enq(OP_LW, 30, 0, 0, 32'd0, 32'd0);
    step();
    chk("fill_refused", 64'(count), 64'd8);
    idle();
    cdb_valid = 2'b01;
    cdb_roben = {5'd0, 5'd7};
    cdb_val = {32'd0, 32'd500};
    step();
    idle();
    step();
    chk("pop_count", 64'(count), 64'd7);
    chk("pop_roben", 64'(out_roben), 64'd8);
    out_ready = 1'b0;
    enq(OP_LW, 20, 0, 0, 32'd0, 32'd0);
    step();
    chk("wrap_count", 64'(count), 64'd8);
    chk("wrap_full", 64'(full), 64'd1);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_roben", 64'(out_roben), 64'd8);
      chk("stall_ea", 64'(out_ea), 64'd500);
      chk("stall_count", 64'(count), 64'd8);
    end
    out_ready = 1'b1;
    step();
    chk("stall_release", 64'(out_roben), 64'd9);

    // Flush with count=5 and an issued entry pending.
    idle();
    flush = 1'b1;
    step();
    idle();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      enq(OP_LW, 1 + k, 0, 0, 32'd0, DW'(k));
      step();
    end
    chk("pre_flush_count", 64'(count), 64'd5);
    chk("pre_flush_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    enq(OP_LW, 15, 0, 0, 32'd0, 32'd0);
    step();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    idle();
    step();
    chk("flush_enq_dropped", 64'(count), 64'd0);

    // Reset in the middle of traffic.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      enq(OP_LW, 1 + k, 0, 0, 32'd0, 32'd0);
      step();
    end
    idle();
    do_reset();
    step();
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_opcode = ($urandom_range(0, 2) == 0) ? OP_SW : OP_LW;
      in_roben  = RW'($urandom_range(1, 7));
      in_rd     = 5'($urandom);
      in_q1     = ($urandom_range(0, 1) == 0) ? '0 : RW'($urandom_range(1, 3));
      in_q2     = ($urandom_range(0, 1) == 0) ? '0 : RW'($urandom_range(1, 3));
      in_v1     = $urandom; in_v2 = $urandom; in_imm = $urandom; in_ea = $urandom;
      cdb_valid = NCDB'($urandom);
      cdb_roben = {RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3))};
      cdb_val   = {$urandom, $urandom};
      rob_head  = RW'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 149) == 0);
      if (i == 1500) do_reset();
      else step();
    end

    idle();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
